t07_tft_cmd_queue: RTL and testbench
====================================

T07_TFT_CMD_QUEUE -- requirements
Module: t07_tft_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of 32-bit command entries (power of two, 2..16).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: wr_en  input  1  push request from memory handler.
REQ-005 Port: wr_data  input  32  command word {delay[31:16], spi_word[15:0]}.
REQ-006 Port: full  output  1  queue holds DEPTH entries.
REQ-007 Port: empty  output  1  queue holds zero entries.
REQ-008 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-009 Port: ovf  output  1  sticky overflow flag.
REQ-010 Port: spi_in  output  32  command word presented to the SPI TFT shifter.
REQ-011 Port: spi_wi  output  1  transfer request to the SPI TFT shifter.
REQ-012 Port: spi_ack  input  1  shifter busy/acknowledge, high while shifting.
REQ-013 Port: spi_miso  input  8  read-back byte from the shifter.
REQ-014 Port: rd_data  output  8  last captured read-back byte.
REQ-015 Port: rd_valid  output  1  one-cycle pulse when rd_data updates.
REQ-016 Port: busy  output  1  sequencer not in IDLE.

Function
REQ-017 Storage: circular buffer, DEPTH x 32, write pointer, read pointer, occupancy counter; pointers wrap DEPTH-1 -> 0.
REQ-018 Push: wr_en=1 and full=0 -> wr_data stored at write pointer, pointer +1, count +1 at next edge.
REQ-019 Push while full=1: data dropped, pointers/count unchanged, ovf set to 1 and held until rst; applies even if a pop occurs in the same cycle.
REQ-020 Pop: only by sequencer (REQ-025); simultaneous accepted push and pop -> count unchanged, both pointers advance.
REQ-021 full = (count==DEPTH), empty = (count==0), both combinational from count.
REQ-022 Sequencer states: IDLE, REQ, XFER, GAP; busy = (state != IDLE).
REQ-023 IDLE: spi_wi=0; if empty=0, register head entry into spi_in, go REQ next cycle.
REQ-024 REQ: spi_wi=1, spi_in held; spi_ack=1 -> XFER; otherwise stay REQ indefinitely.
REQ-025 XFER: spi_wi=1, spi_in held; first cycle with spi_ack=0 -> go GAP, pop head, load gap counter with spi_in[31:16]+2 (17-bit arithmetic, no wrap).
REQ-026 Read capture: on the XFER->GAP cycle, if spi_in[15:8]==8'h40, rd_data <= spi_miso and rd_valid=1 for exactly the following cycle; otherwise rd_data unchanged, rd_valid=0.
REQ-027 GAP: spi_wi=0, spi_in held stable (shifter reads delay field); counter decrements each cycle; at counter==1 -> IDLE.
REQ-028 Minimum GAP length 2 cycles (delay field 0); back-to-back commands therefore separated by at least 3 spi_wi-low cycles including IDLE.
REQ-029 Pushes during REQ/XFER/GAP are accepted normally; the in-flight entry is not popped until XFER ends, so it counts toward occupancy.
REQ-030 spi_in changes only on the IDLE->REQ transition.

Reset
REQ-031 rst=1 at any edge, including mid-transfer: state=IDLE, pointers=0, count=0, ovf=0, spi_in=0, spi_wi=0, rd_data=0, rd_valid=0, gap counter=0; queue contents discarded.
REQ-032 Outputs after reset: empty=1, full=0, busy=0; first push accepted on the first edge with rst=0.

Verification
REQ-033 Push 0x0003_1234, shifter acks 16 cycles -> spi_wi high from REQ through XFER, spi_in=0x0003_1234, GAP lasts 5 cycles, count 1->0, busy falls.
REQ-034 Push 0x0000_4012, spi_miso=8'hA5 when ack falls -> rd_data=8'hA5, rd_valid single-cycle pulse; repeat with 0x0000_2012 -> no rd_valid.
REQ-035 With spi_ack tied 0, push DEPTH entries then one more -> full=1, count=DEPTH, ovf=1, sequencer stuck in REQ with spi_wi=1, extra word absent.
REQ-036 Push DEPTH+2 words in stream while shifter services them -> wrap-around exercised, words emitted in push order, no loss, ovf=0.
REQ-037 Assert rst during XFER with 2 entries queued -> next cycle spi_wi=0, count=0, empty=1, busy=0; subsequent push transfers normally.
REQ-038 Push on same cycle as XFER->GAP pop with count=2 -> count stays 2, correct order preserved.

Source files
------------

// File: rtl/t07_tft_cmd_queue.sv
// Command FIFO feeding an SPI TFT shifter. A small sequencer requests each
// transfer, pops the entry when the shifter finishes, and then waits for that
// command's delay gap before starting the next one.
module t07_tft_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [31:0]              wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [31:0]              spi_in,
    output logic                     spi_wi,
    input  logic                     spi_ack,
    input  logic [7:0]               spi_miso,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [16:0]   gap_cnt;
    logic          push_ok, pop, load;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign busy    = (state_q != IDLE);
    assign push_ok = wr_en && !full;

    always_comb begin
        state_d = state_q;
        spi_wi  = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                spi_wi = 1'b1;
                if (spi_ack) state_d = XFER;
            end
            XFER: begin
                spi_wi = 1'b1;
                if (!spi_ack) begin
                    pop     = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 17'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Storage has no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_en && full) ovf <= 1'b1;
        end
    end

    // The delay field stays on spi_in through GAP, so spi_in only reloads in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi_in   <= '0;
            gap_cnt  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (load) spi_in <= mem[rd_ptr];
            if (pop) begin
                gap_cnt <= {1'b0, spi_in[31:16]} + 17'd2;
                if (spi_in[15:8] == 8'h40) begin
                    rd_data  <= spi_miso;
                    rd_valid <= 1'b1;
                end
            end else if (state_q == GAP) begin
                gap_cnt <= gap_cnt - 17'd1;
            end
        end
    end
endmodule

// File: tb/tb_t07_tft_cmd_queue.sv
// Directed bench for t07_tft_cmd_queue with DEPTH=4 and hand-computed expectations.
module tb_t07_tft_cmd_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, wr_en, spi_ack;
    logic [31:0] wr_data;
    logic [7:0]  spi_miso;
    logic        full, empty, ovf, spi_wi, rd_valid, busy;
    logic [2:0]  count;
    logic [31:0] spi_in;
    logic [7:0]  rd_data;

    int checks = 0;
    int failures = 0;

    t07_tft_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .ovf(ovf),
        .spi_in(spi_in), .spi_wi(spi_wi), .spi_ack(spi_ack),
        .spi_miso(spi_miso), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && busy; i++) tick();
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Wait for a request, check the word, ack for one cycle, then drain the gap.
    task automatic serve(input string tag, input logic [31:0] exp, input logic [7:0] miso);
        for (int i = 0; i < 200 && !spi_wi; i++) tick();
        chk({tag, "_word"}, spi_in, exp);
        spi_ack = 1'b1;
        tick();
        spi_miso = miso;
        spi_ack  = 1'b0;
        tick();
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        int n;
        logic [31:0] stream [6];
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; spi_ack = 1'b0; spi_miso = '0;
        tick(); tick();
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_spi_in", spi_in, 32'd0);
        chk("rst_wi", {31'd0, spi_wi}, 32'd0);
        rst = 1'b0;

        // Basic transfer with delay 3: gap of 5 cycles.
        push(32'h0003_1234);
        chk("t1_count1", {29'd0, count}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("t1_req_wi", {31'd0, spi_wi}, 32'd1);
        chk("t1_spi_in", spi_in, 32'h0003_1234);
        spi_ack = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("t1_xfer_wi", {31'd0, spi_wi}, 32'd1);
        chk("t1_xfer_count", {29'd0, count}, 32'd1);
        spi_ack = 1'b0;
        tick();
        chk("t1_gap_wi", {31'd0, spi_wi}, 32'd0);
        chk("t1_gap_count", {29'd0, count}, 32'd0);
        chk("t1_gap_hold", spi_in, 32'h0003_1234);
        n = 1;
        for (int i = 0; i < 50 && busy; i++) begin
            tick();
            if (busy) n++;
        end
        chk("t1_gap_len", n, 32'd5);
        chk("t1_busy_fall", {31'd0, busy}, 32'd0);

        // Read-back capture and non-read command.
        push(32'h0000_4012);
        tick();
        spi_ack = 1'b1; tick();
        spi_miso = 8'hA5; spi_ack = 1'b0; tick();
        chk("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("t2_rd_data", {24'd0, rd_data}, 32'hA5);
        tick();
        chk("t2_rd_pulse", {31'd0, rd_valid}, 32'd0);
        wait_idle("t2_idle");
        push(32'h0000_2012);
        tick();
        spi_ack = 1'b1; tick();
        spi_miso = 8'h5A; spi_ack = 1'b0; tick();
        chk("t2_no_valid", {31'd0, rd_valid}, 32'd0);
        chk("t2_rd_keep", {24'd0, rd_data}, 32'hA5);
        wait_idle("t2b_idle");

        // Push coinciding with the pop at XFER->GAP while count=2.
        push(32'h0000_0111);
        push(32'h0000_0222);
        chk("t3_req_word", spi_in, 32'h0000_0111);
        spi_ack = 1'b1; tick();
        spi_ack = 1'b0; wr_en = 1'b1; wr_data = 32'h0000_0333;
        tick();
        wr_en = 1'b0;
        chk("t3_count_same", {29'd0, count}, 32'd2);
        wait_idle("t3_idle");
        serve("t3_b", 32'h0000_0222, 8'h00);
        serve("t3_c", 32'h0000_0333, 8'h00);
        chk("t3_empty", {31'd0, empty}, 32'd1);

        // Streamed pushes while the shifter drains: pointer wrap, no loss.
        for (int i = 0; i < 6; i++) stream[i] = 32'h0000_0A00 + i;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int k = 0; k < 200 && full; k++) tick();
                    push(stream[i]);
                end
            end
            begin
                for (int i = 0; i < 6; i++) serve("t4_stream", stream[i], 8'h00);
            end
        join
        chk("t4_ovf", {31'd0, ovf}, 32'd0);
        chk("t4_empty", {31'd0, empty}, 32'd1);

        // Overflow with the shifter never acknowledging.
        for (int i = 0; i < DEPTH; i++) push(32'h0000_0B00 + i);
        push(32'hDEAD_BEEF);
        chk("t5_full", {31'd0, full}, 32'd1);
        chk("t5_count", {29'd0, count}, DEPTH);
        chk("t5_ovf", {31'd0, ovf}, 32'd1);
        tick(); tick();
        chk("t5_stuck_wi", {31'd0, spi_wi}, 32'd1);
        chk("t5_stuck_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < DEPTH; i++) serve("t5_drain", 32'h0000_0B00 + i, 8'h00);
        chk("t5_no_extra", {31'd0, empty}, 32'd1);
        chk("t5_ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset in the middle of a transfer.
        push(32'h0000_0C01);
        push(32'h0000_0C02);
        spi_ack = 1'b1; tick();
        rst = 1'b1; tick();
        rst = 1'b0; spi_ack = 1'b0;
        chk("t6_wi", {31'd0, spi_wi}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_ovf", {31'd0, ovf}, 32'd0);
        chk("t6_rd_data", {24'd0, rd_data}, 32'd0);
        push(32'h0000_0C03);
        serve("t6_after", 32'h0000_0C03, 8'h00);
        chk("t6_final_empty", {31'd0, empty}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
